memory_write_back: RTL
======================

// Module: memory_write_back
// PURPOSE
// - MEM + WB stages of the 5-stage MIPS pipeline: takes EX/MEM results, performs the data-memory access,
//   holds the MEM/WB pipeline register and drives the register-file write port of the decode stage.
// - Producer end of the decode stage's write interface (write_data_into_reg, write_register_mem_wb,
//   ctrl_regWrite_mem_wb). Adds alignment checking with a sticky fault flag and a saturating fault counter.
// PARAMETERS
// - DMEM_WORDS  256  data memory depth in 32-bit words; power of two, >= 4
// - FCNT_W      8    width of fault_count
// PORTS
// - clk                    in   1   pipeline clock, rising edge
// - reset                  in   1   asynchronous, active-high reset
// - ctrl_memRead_ex_mem    in   1   load instruction in MEM
// - ctrl_memWrite_ex_mem   in   1   store instruction in MEM
// - ctrl_memToReg_ex_mem   in   1   1: WB data from memory; 0: from ALU
// - ctrl_regWrite_ex_mem   in   1   instruction writes a register
// - write_register_ex_mem  in   5   destination register number
// - alu_result_ex_mem      in   32  ALU result / effective byte address
// - write_data_ex_mem      in   32  store data (rt value)
// - mem_size_ex_mem        in   2   00 word, 01 half, 10 byte, 11 reserved (treated as word)
// - mem_unsigned_ex_mem    in   1   1: zero-extend sub-word loads
// - write_data_into_reg    out  32  WB data to register file
// - ctrl_regWrite_mem_wb   out  1   register write enable
// - write_register_mem_wb  out  5   register write address
// - misaligned_fault       out  1   sticky alignment-fault flag
// - fault_count            out  FCNT_W  saturating count of faulting accesses
// BEHAVIOUR
// - Reset (async, active-high): MEM/WB register, misaligned_fault, fault_count and all DMEM words -> 0.
//   All outputs read 0 while reset is high. A store presented in a cycle with reset high is discarded.
// - Word index: alu_result_ex_mem[log2(DMEM_WORDS)+1:2]. Upper address bits are ignored, so addresses
//   wrap modulo 4*DMEM_WORDS (e.g. 0x400 -> word 0 when DMEM_WORDS=256).
// - DMEM read is combinational from the current index. A store writes the array on the clk edge.
// - Latency is 1 cycle. On each clk edge the MEM/WB register captures:
//   - regWrite = ctrl_regWrite_ex_mem & (write_register_ex_mem != 0) & ~fault
//   - write_register
//   - memToReg
//   - load data
//   - alu_result
// - write_data_into_reg = memToReg_wb ? load_data_wb : alu_wb (combinational from the register).
// - Alignment fault: memRead or memWrite, with a word access and addr[1:0] != 0, or a half access and addr[0] != 0.
//   - The store is suppressed; load data is 0; regWrite is forced to 0.
//   - misaligned_fault is set on the edge and stays 1 until reset.
//   - fault_count increments by 1 per faulting cycle and saturates at all-ones.
// - memRead and memWrite both 1 (illegal): store is performed, regWrite is forced to 0, not counted as a fault.
// - Store then load to the same address on consecutive cycles: the load sees the stored data (the write lands first).
// - write_register 0 never produces ctrl_regWrite_mem_wb = 1.
// CONFIGURATION
// - MEM_SUBWORD_EN defined:
//   - mem_size_ex_mem is honoured. Little-endian lanes: byte lane = addr[1:0] -> bits [8*lane+7 : 8*lane];
//     half lane = addr[1].
//   - Sub-word stores are a read-modify-write merge into the addressed lane only.
//   - Sub-word loads sign-extend, or zero-extend when mem_unsigned_ex_mem = 1.
// - MEM_SUBWORD_EN undefined:
//   - mem_size_ex_mem and mem_unsigned_ex_mem are ignored; every access is a word access.
//   - The alignment rule for word accesses applies to all addresses.
// TESTING
// - Reset high mid-stream -> all outputs 0 at once. DMEM[4] = 0 after a store to 0x10 issued during reset.
// - sw 0xDEADBEEF @0x10; then lw @0x10, rd=8, memToReg=1 -> next cycle data = 0xDEADBEEF, wr_reg = 8, regWrite = 1.
// - ALU op alu = 0x1234, rd = 0, regWrite = 1 -> ctrl_regWrite_mem_wb = 0.
//   Same op with rd = 3 -> data = 0x1234, regWrite = 1.
// - lw @0x12 -> regWrite = 0, misaligned_fault = 1, fault_count = 1.
//   sw @0x13 -> DMEM unchanged, fault_count = 2.
// - Wrap: sw 0xA5A5A5A5 @0x400 (DMEM_WORDS = 256) -> lw @0x0 returns 0xA5A5A5A5.
// - MEM_SUBWORD_EN: sw 0 @0x10; sb 0x80 @0x11 -> word = 0x00008000; lb @0x11 -> 0xFFFFFF80; lbu -> 0x00000080;
//   lh @0x11 -> fault.

Source files
------------

// File: rtl/memory_write_back_if.sv
// Bundle between the EX/MEM pipeline register, the MEM+WB stage and the
// register-file write port of the decode stage.
// master: drives the EX/MEM signals and observes the write-back results.
// slave : the MEM+WB stage itself (memory_write_back).
interface memory_write_back_if #(
    parameter int FCNT_W = 8
);
    logic              ctrl_memRead_ex_mem;
    logic              ctrl_memWrite_ex_mem;
    logic              ctrl_memToReg_ex_mem;
    logic              ctrl_regWrite_ex_mem;
    logic [4:0]        write_register_ex_mem;
    logic [31:0]       alu_result_ex_mem;
    logic [31:0]       write_data_ex_mem;
    logic [1:0]        mem_size_ex_mem;
    logic              mem_unsigned_ex_mem;

    logic [31:0]       write_data_into_reg;
    logic              ctrl_regWrite_mem_wb;
    logic [4:0]        write_register_mem_wb;
    logic              misaligned_fault;
    logic [FCNT_W-1:0] fault_count;

    modport master (
        output ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem, ctrl_memToReg_ex_mem,
               ctrl_regWrite_ex_mem, write_register_ex_mem, alu_result_ex_mem,
               write_data_ex_mem, mem_size_ex_mem, mem_unsigned_ex_mem,
        input  write_data_into_reg, ctrl_regWrite_mem_wb, write_register_mem_wb,
               misaligned_fault, fault_count
    );

    modport slave (
        input  ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem, ctrl_memToReg_ex_mem,
               ctrl_regWrite_ex_mem, write_register_ex_mem, alu_result_ex_mem,
               write_data_ex_mem, mem_size_ex_mem, mem_unsigned_ex_mem,
        output write_data_into_reg, ctrl_regWrite_mem_wb, write_register_mem_wb,
               misaligned_fault, fault_count
    );
endinterface

// File: rtl/memory_write_back.sv
// MEM + WB stages of the 5-stage MIPS pipeline: data-memory access,
// MEM/WB pipeline register and register-file write port, with alignment
// checking (sticky fault flag plus saturating fault counter).
// Optional feature macro: MEM_SUBWORD_EN -- when defined, byte/half
// accesses (little-endian lanes, sign/zero-extended loads, RMW sub-word
// stores) are honoured; otherwise every access is a word access.
module memory_write_back #(
    parameter int DMEM_WORDS = 256,
    parameter int FCNT_W     = 8
) (
    input logic              clk,
    input logic              reset,
    memory_write_back_if.slave bus
);
    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0]       dmem [DMEM_WORDS];
    logic [AW-1:0]     word_idx;
    logic [1:0]        addr_lo;
    logic [31:0]       rdata;

    logic              is_access;
    logic              illegal_rw;
    logic              fault;
    logic              store_en;
    logic              reg_we;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    logic              regwrite_wb;
    logic [4:0]        wreg_wb;
    logic              memtoreg_wb;
    logic [31:0]       load_wb;
    logic [31:0]       alu_wb;
    logic              fault_q;
    logic [FCNT_W-1:0] fcnt_q;

    // Upper address bits are dropped, so addresses wrap modulo 4*DMEM_WORDS.
    assign word_idx   = bus.alu_result_ex_mem[AW+1:2];
    assign addr_lo    = bus.alu_result_ex_mem[1:0];
    assign rdata      = dmem[word_idx];
    assign is_access  = bus.ctrl_memRead_ex_mem | bus.ctrl_memWrite_ex_mem;
    assign illegal_rw = bus.ctrl_memRead_ex_mem & bus.ctrl_memWrite_ex_mem;

`ifdef MEM_SUBWORD_EN
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    assign lane_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_half = rdata[{addr_lo[1], 4'b0000} +: 16];

    // Size decode: alignment check, lane extraction/extension and store merge.
    always_comb begin
        fault      = 1'b0;
        load_data  = rdata;
        store_word = rdata;
        case (bus.mem_size_ex_mem)
            2'b01: begin
                fault     = is_access & addr_lo[0];
                load_data = {{16{~bus.mem_unsigned_ex_mem & lane_half[15]}}, lane_half};
                store_word[{addr_lo[1], 4'b0000} +: 16] = bus.write_data_ex_mem[15:0];
            end
            2'b10: begin
                load_data = {{24{~bus.mem_unsigned_ex_mem & lane_byte[7]}}, lane_byte};
                store_word[{addr_lo, 3'b000} +: 8] = bus.write_data_ex_mem[7:0];
            end
            default: begin
                fault      = is_access & (addr_lo != 2'b00);
                store_word = bus.write_data_ex_mem;
            end
        endcase
        if (fault) begin
            load_data = '0;
        end
    end
`else
    logic unused_size_bits;
    assign unused_size_bits = ^{bus.mem_size_ex_mem, bus.mem_unsigned_ex_mem};

    // Word-only access: any non-zero low address bits fault.
    always_comb begin
        fault      = is_access & (addr_lo != 2'b00);
        load_data  = fault ? '0 : rdata;
        store_word = bus.write_data_ex_mem;
    end
`endif

    assign store_en = bus.ctrl_memWrite_ex_mem & ~fault;
    assign reg_we   = bus.ctrl_regWrite_ex_mem & (bus.write_register_ex_mem != 5'd0)
                      & ~fault & ~illegal_rw;

    // Data memory array; cleared by reset, written on the edge by non-faulting stores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DMEM_WORDS; i++) begin
                dmem[i] <= '0;
            end
        end else if (store_en) begin
            dmem[word_idx] <= store_word;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_wb <= 1'b0;
            wreg_wb     <= '0;
            memtoreg_wb <= 1'b0;
            load_wb     <= '0;
            alu_wb      <= '0;
        end else begin
            regwrite_wb <= reg_we;
            wreg_wb     <= bus.write_register_ex_mem;
            memtoreg_wb <= bus.ctrl_memToReg_ex_mem;
            load_wb     <= load_data;
            alu_wb      <= bus.alu_result_ex_mem;
        end
    end

    // Sticky fault flag and saturating fault counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
            fcnt_q  <= '0;
        end else if (fault) begin
            fault_q <= 1'b1;
            if (fcnt_q != '1) begin
                fcnt_q <= fcnt_q + 1'b1;
            end
        end
    end

    assign bus.write_data_into_reg   = memtoreg_wb ? load_wb : alu_wb;
    assign bus.ctrl_regWrite_mem_wb  = regwrite_wb;
    assign bus.write_register_mem_wb = wreg_wb;
    assign bus.misaligned_fault      = fault_q;
    assign bus.fault_count           = fcnt_q;
endmodule
